mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between an instruction-fetch and a load/store requester.
// Round-robin on ties; one access in flight; every output is registered.
module mem_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 16,
  parameter int RAM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_gnt,
  output logic          ls_valid,
  output logic [DW-1:0] ls_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic       owner;       // 0 = IF, 1 = LS
  logic       last_owner;
  logic       cur_we;
  logic       any_req;
  logic       win_ls;

  always_comb begin
    any_req   = if_req | ls_req;
    win_ls    = (if_req && ls_req) ? ~last_owner : ls_req;
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:  if (any_req) state_nxt = ISSUE;
      ISSUE: begin
        if (cur_we || RAM_LAT == 1) begin
          state_nxt = RESP;
        end else begin
          state_nxt = WAIT;
          cnt_nxt   = 2'(RAM_LAT - 2);
        end
      end
      WAIT: begin
        if (cnt == 2'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 2'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= 1'b0;
      last_owner <= 1'b1;
      cur_we     <= 1'b0;
      if_gnt     <= 1'b0;
      ls_gnt     <= 1'b0;
      if_valid   <= 1'b0;
      ls_valid   <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      if_rdata   <= '0;
      ls_rdata   <= '0;
      busy       <= 1'b0;
    end else begin
      if_gnt   <= 1'b0;
      ls_gnt   <= 1'b0;
      ram_en   <= 1'b0;
      ram_we   <= 1'b0;
      if_valid <= (state_nxt == RESP) && !owner;
      ls_valid <= (state_nxt == RESP) && owner;
      busy     <= (state_nxt != IDLE);
      // ram_addr/ram_wdata double as the latched request for the whole access
      if (state == IDLE && any_req) begin
        owner      <= win_ls;
        last_owner <= win_ls;
        cur_we     <= win_ls && ls_we;
        if_gnt     <= !win_ls;
        ls_gnt     <= win_ls;
        ram_en     <= 1'b1;
        ram_we     <= win_ls && ls_we;
        ram_addr   <= win_ls ? ls_addr : if_addr;
        ram_wdata  <= win_ls ? ls_wdata : '0;
      end
      // Read data lands on the edge that enters RESP, alongside the valid pulse
      if (state_nxt == RESP && !cur_we) begin
        if (owner) ls_rdata <= ram_rdata;
        else       if_rdata <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at RAM_LAT=1 driven from a vector table,
// one at RAM_LAT=3 for the wait-state and mid-access reset sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, if_req, ls_req, ls_we;
  logic [7:0]  if_addr, ls_addr;
  logic [15:0] ls_wdata, ram_rdata;

  logic        a_igt, a_iv, a_lgt, a_lv, a_en, a_we, a_busy;
  logic [15:0] a_ird, a_lrd, a_wd;
  logic [7:0]  a_addr;
  logic        b_igt, b_iv, b_lgt, b_lv, b_en, b_we, b_busy;
  logic [15:0] b_ird, b_lrd, b_wd;
  logic [7:0]  b_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(8), .DW(16), .RAM_LAT(1)) u1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(a_igt), .if_valid(a_iv), .if_rdata(a_ird),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(a_lgt), .ls_valid(a_lv), .ls_rdata(a_lrd),
    .ram_en(a_en), .ram_we(a_we), .ram_addr(a_addr), .ram_wdata(a_wd),
    .ram_rdata(ram_rdata), .busy(a_busy)
  );

  mem_arbiter #(.AW(8), .DW(16), .RAM_LAT(3)) u3 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(b_igt), .if_valid(b_iv), .if_rdata(b_ird),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(b_lgt), .ls_valid(b_lv), .ls_rdata(b_lrd),
    .ram_en(b_en), .ram_we(b_we), .ram_addr(b_addr), .ram_wdata(b_wd),
    .ram_rdata(ram_rdata), .busy(b_busy)
  );

  typedef struct {
    logic        rst, ifr;
    logic [7:0]  ifa;
    logic        lsr, lswe;
    logic [7:0]  lsa;
    logic [15:0] lswd, rd;
    logic        igt, lgt, iv, lv, en, we;
    logic [7:0]  addr;
    logic [15:0] wd, ird, lrd;
    logic        busy;
  } vec_t;

  vec_t vecs[$];
  vec_t v;
  int   gnt_cyc[$];
  int   gnt_own[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int r, input int ifr, input int ifa, input int lsr, input int lswe,
                     input int lsa, input int lswd, input int rd,
                     input int igt, input int lgt, input int iv, input int lv, input int en,
                     input int we, input int addr, input int wd, input int ird, input int lrd,
                     input int bsy);
    vec_t t;
    t.rst = 1'(r);    t.ifr = 1'(ifr);   t.ifa = 8'(ifa);
    t.lsr = 1'(lsr);  t.lswe = 1'(lswe); t.lsa = 8'(lsa);
    t.lswd = 16'(lswd); t.rd = 16'(rd);
    t.igt = 1'(igt);  t.lgt = 1'(lgt);   t.iv = 1'(iv);   t.lv = 1'(lv);
    t.en = 1'(en);    t.we = 1'(we);     t.addr = 8'(addr);
    t.wd = 16'(wd);   t.ird = 16'(ird);  t.lrd = 16'(lrd); t.busy = 1'(bsy);
    vecs.push_back(t);
  endtask

  // Structural invariants on both instances, sampled mid-cycle
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("inv_gnt_excl", 32'(a_igt & a_lgt) | 32'(b_igt & b_lgt), 32'd0);
      check("inv_valid_excl", 32'(a_iv & a_lv) | 32'(b_iv & b_lv), 32'd0);
      check("inv_we_en", 32'(a_we & ~a_en) | 32'(b_we & ~b_en), 32'd0);
    end
  end

  initial begin
    rst = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0; ram_rdata = '0;

    //   rst ifr ifa    lsr we lsa    lswd     rd        igt lgt iv lv en we addr   wd       ird      lrd      busy
    add(1, 0, 0,     0, 0, 0,     0,       0,        0, 0, 0, 0, 0, 0, 0,     0,       0,       0,       0);
    add(0, 1, 'h10,  0, 0, 0,     0,       'hA5A5,   1, 0, 0, 0, 1, 0, 'h10,  0,       0,       0,       1);
    add(0, 0, 'h10,  0, 0, 0,     0,       'hA5A5,   0, 0, 1, 0, 0, 0, 'h10,  0,       'hA5A5,  0,       1);
    add(0, 0, 0,     0, 0, 0,     0,       'hA5A5,   0, 0, 0, 0, 0, 0, 'h10,  0,       'hA5A5,  0,       0);
    add(0, 0, 0,     1, 1, 'h22,  'h1234,  0,        0, 1, 0, 0, 1, 1, 'h22,  'h1234,  'hA5A5,  0,       1);
    add(0, 0, 0,     0, 1, 'h55,  'hFFFF,  'h9999,   0, 0, 0, 1, 0, 0, 'h22,  'h1234,  'hA5A5,  0,       1);
    add(0, 0, 0,     0, 0, 0,     0,       0,        0, 0, 0, 0, 0, 0, 'h22,  'h1234,  'hA5A5,  0,       0);
    add(0, 0, 0,     1, 0, 'h30,  0,       'h7777,   0, 1, 0, 0, 1, 0, 'h30,  0,       'hA5A5,  0,       1);
    add(0, 0, 0,     0, 0, 'h30,  0,       'h7777,   0, 0, 0, 1, 0, 0, 'h30,  0,       'hA5A5,  'h7777,  1);
    add(0, 0, 0,     1, 0, 'h31,  0,       'h8888,   0, 0, 0, 0, 0, 0, 'h30,  0,       'hA5A5,  'h7777,  0);
    add(0, 0, 0,     1, 0, 'h31,  0,       'h8888,   0, 1, 0, 0, 1, 0, 'h31,  0,       'hA5A5,  'h7777,  1);
    add(0, 0, 0,     0, 0, 'h31,  0,       'h8888,   0, 0, 0, 1, 0, 0, 'h31,  0,       'hA5A5,  'h8888,  1);
    add(0, 1, 'h40,  0, 0, 0,     0,       0,        0, 0, 0, 0, 0, 0, 'h31,  0,       'hA5A5,  'h8888,  0);
    add(0, 0, 'h40,  0, 0, 0,     0,       0,        0, 0, 0, 0, 0, 0, 'h31,  0,       'hA5A5,  'h8888,  0);
    add(0, 1, 'h44,  1, 0, 'h48,  0,       0,        1, 0, 0, 0, 1, 0, 'h44,  0,       'hA5A5,  'h8888,  1);
    add(0, 0, 'h44,  1, 0, 'h48,  0,       'h1111,   0, 0, 1, 0, 0, 0, 'h44,  0,       'h1111,  'h8888,  1);
    add(0, 0, 0,     1, 0, 'h48,  0,       0,        0, 0, 0, 0, 0, 0, 'h44,  0,       'h1111,  'h8888,  0);
    add(0, 0, 0,     1, 0, 'h48,  0,       0,        0, 1, 0, 0, 1, 0, 'h48,  0,       'h1111,  'h8888,  1);
    add(1, 0, 0,     1, 0, 'h48,  0,       'h2222,   0, 0, 0, 0, 0, 0, 0,     0,       0,       0,       0);
    add(0, 0, 0,     0, 0, 0,     0,       'h2222,   0, 0, 0, 0, 0, 0, 0,     0,       0,       0,       0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      rst = v.rst; if_req = v.ifr; if_addr = v.ifa;
      ls_req = v.lsr; ls_we = v.lswe; ls_addr = v.lsa; ls_wdata = v.lswd; ram_rdata = v.rd;
      step();
      check($sformatf("row%0d_flags", i), 32'({a_igt, a_lgt, a_iv, a_lv, a_en, a_we, a_busy}),
            32'({v.igt, v.lgt, v.iv, v.lv, v.en, v.we, v.busy}));
      check($sformatf("row%0d_addr", i), 32'(a_addr), 32'(v.addr));
      check($sformatf("row%0d_wdata", i), 32'(a_wd), 32'(v.wd));
      check($sformatf("row%0d_if_rdata", i), 32'(a_ird), 32'(v.ird));
      check($sformatf("row%0d_ls_rdata", i), 32'(a_lrd), 32'(v.lrd));
    end

    // Tie with both requests held: IF first, then alternating, RAM_LAT+2 apart
    rst = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; ram_rdata = '0;
    step();
    rst = 1'b0; if_req = 1'b1; ls_req = 1'b1; if_addr = 8'h01; ls_addr = 8'h02;
    for (int c = 0; c < 16; c++) begin
      step();
      if (a_igt) begin gnt_cyc.push_back(c); gnt_own.push_back(0); end
      if (a_lgt) begin gnt_cyc.push_back(c); gnt_own.push_back(1); end
    end
    check("tie_grant_count", 32'(gnt_cyc.size()), 32'd6);
    if (gnt_cyc.size() >= 4) begin
      check("tie_first_cycle", 32'(gnt_cyc[0]), 32'd0);
      for (int k = 0; k < 4; k++) begin
        check($sformatf("tie_owner%0d", k), 32'(gnt_own[k]), 32'(k % 2));
        if (k > 0) check($sformatf("tie_gap%0d", k), 32'(gnt_cyc[k] - gnt_cyc[k-1]), 32'd3);
      end
    end

    // RAM_LAT=3 read: two WAIT cycles, capture of the late-arriving word
    rst = 1'b1; if_req = 1'b0; ls_req = 1'b0;
    step();
    rst = 1'b0; if_req = 1'b1; if_addr = 8'h60; ram_rdata = 16'hDEAD;
    step();
    check("l3_issue", 32'({b_igt, b_en, b_iv, b_busy}), 32'b1101);
    check("l3_issue_addr", 32'(b_addr), 32'h60);
    if_req = 1'b0;
    step();
    check("l3_wait1", 32'({b_igt, b_en, b_iv, b_busy}), 32'b0001);
    step();
    check("l3_wait2", 32'({b_igt, b_en, b_iv, b_busy}), 32'b0001);
    ram_rdata = 16'hBEEF;
    step();
    check("l3_resp", 32'({b_igt, b_en, b_iv, b_busy}), 32'b0011);
    check("l3_rdata", 32'(b_ird), 32'hBEEF);
    ram_rdata = 16'h0000;
    step();
    check("l3_idle", 32'({b_iv, b_busy}), 32'b00);
    check("l3_rdata_hold", 32'(b_ird), 32'hBEEF);

    // Reset while in WAIT: access dropped, held request re-arbitrated straight after
    if_req = 1'b1; if_addr = 8'h70; ram_rdata = 16'h5555;
    step();
    check("rw_issue", 32'(b_igt), 32'd1);
    step();
    check("rw_in_wait", 32'({b_en, b_busy}), 32'b01);
    rst = 1'b1;
    step();
    check("rw_after_rst", 32'({b_igt, b_lgt, b_iv, b_lv, b_en, b_we, b_busy}), 32'd0);
    check("rw_rdata_clr", 32'(b_ird), 32'd0);
    rst = 1'b0;
    step();
    check("rw_regrant", 32'({b_igt, b_en, b_iv, b_lv}), 32'b1100);
    check("rw_regrant_addr", 32'(b_addr), 32'h70);
    if_req = 1'b0;
    step();
    step();
    check("rw_no_early_valid", 32'({b_iv, b_lv}), 32'd0);
    step();
    check("rw_resp", 32'(b_iv), 32'd1);
    check("rw_resp_rdata", 32'(b_ird), 32'h5555);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
